// File: rtl/controlador_sram_64_if.sv
// Request/response bundle between the test/filter FSM and the SRAM controller.
//   leer / escribir        : one-cycle read / write request pulses (FSM -> controller)
//   direccion_memoria      : base SRAM word address of the request
//   datos_por_escribir     : write data, sampled when the request is accepted
//   datos_leidos           : assembled read data (controller -> FSM)
//   operacion_completada   : one-cycle completion pulse
//   ocupado                : high from acceptance through the completion pulse
// Modports: master = requesting FSM, slave = controller.
interface controlador_sram_64_if #(
   parameter int ADDRESS_BITS = 18,
   parameter int DATA_BITS    = 64
);
   logic                    leer;
   logic                    escribir;
   logic [ADDRESS_BITS-1:0] direccion_memoria;
   logic [DATA_BITS-1:0]    datos_por_escribir;
   logic [DATA_BITS-1:0]    datos_leidos;
   logic                    operacion_completada;
   logic                    ocupado;

   modport master (
      output leer, escribir, direccion_memoria, datos_por_escribir,
      input  datos_leidos, operacion_completada, ocupado
   );

   modport slave (
      input  leer, escribir, direccion_memoria, datos_por_escribir,
      output datos_leidos, operacion_completada, ocupado
   );
endinterface

// File: rtl/controlador_sram_64.sv
// SRAM controller: executes one DATA_BITS read/write request as PALABRAS
// consecutive SRAM_BITS accesses on an asynchronous SRAM, then pulses
// operacion_completada.
//   clk, reset     : rising-edge clock, asynchronous active-low reset
//   bus            : request/response bundle (slave side)
//   sram_direccion : SRAM address (base + sub-word index, wraps)
//   sram_datos     : bidirectional SRAM data, driven only during writes
//   sram_*_n       : active-low SRAM strobes
module controlador_sram_64 #(
   parameter int ADDRESS_BITS  = 18,
   parameter int DATA_BITS     = 64,
   parameter int SRAM_BITS     = 16,
   parameter int CICLOS_ESPERA = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   controlador_sram_64_if.slave    bus,
   output logic [ADDRESS_BITS-1:0] sram_direccion,
   inout  wire  [SRAM_BITS-1:0]    sram_datos,
   output logic                    sram_ce_n,
   output logic                    sram_oe_n,
   output logic                    sram_we_n,
   output logic                    sram_ub_n,
   output logic                    sram_lb_n
);
   localparam int PALABRAS = DATA_BITS / SRAM_BITS;
   localparam int KW = (PALABRAS > 1) ? $clog2(PALABRAS) : 1;
   localparam int EW = (CICLOS_ESPERA > 1) ? $clog2(CICLOS_ESPERA) : 1;
   localparam logic [KW-1:0] K_ULT = KW'(PALABRAS - 1);
   localparam logic [EW-1:0] E_ULT = EW'(CICLOS_ESPERA - 1);

   typedef enum logic [2:0] {
      E_REPOSO, E_PREPARAR, E_ACCESO, E_RETENER, E_COMPLETO
   } estado_t;

   estado_t                 estado_q, estado_d;
   logic [KW-1:0]           k_q, k_d;
   logic [EW-1:0]           espera_q, espera_d;
   logic                    escritura_q, escritura_d;
   logic [ADDRESS_BITS-1:0] base_q, base_d;
   logic [DATA_BITS-1:0]    wdata_q, wdata_d;
   logic [DATA_BITS-1:0]    rdata_q, rdata_d;
   logic                    conduce;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estado_q    <= E_REPOSO;
         k_q         <= '0;
         espera_q    <= '0;
         escritura_q <= 1'b0;
         base_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
      end else begin
         estado_q    <= estado_d;
         k_q         <= k_d;
         espera_q    <= espera_d;
         escritura_q <= escritura_d;
         base_q      <= base_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
      end
   end

   // Next state and datapath
   always_comb begin
      estado_d    = estado_q;
      k_d         = k_q;
      espera_d    = espera_q;
      escritura_d = escritura_q;
      base_d      = base_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      case (estado_q)
         E_REPOSO: begin
            // escribir wins when both are high; the read is simply dropped
            if (bus.escribir || bus.leer) begin
               estado_d    = E_PREPARAR;
               k_d         = '0;
               escritura_d = bus.escribir;
               base_d      = bus.direccion_memoria;
               wdata_d     = bus.datos_por_escribir;
            end
         end
         E_PREPARAR: begin
            estado_d = E_ACCESO;
            espera_d = '0;
         end
         E_ACCESO: begin
            if (espera_q == E_ULT) begin
               estado_d = E_RETENER;
               // sample as late as possible so the SRAM access time is covered
               if (!escritura_q)
                  rdata_d[k_q*SRAM_BITS +: SRAM_BITS] = sram_datos;
            end else begin
               espera_d = espera_q + 1'b1;
            end
         end
         E_RETENER: begin
            if (k_q == K_ULT) begin
               estado_d = E_COMPLETO;
            end else begin
               k_d      = k_q + 1'b1;
               estado_d = E_PREPARAR;
            end
         end
         E_COMPLETO: estado_d = E_REPOSO;
         default:    estado_d = E_REPOSO;
      endcase
   end

   // Outputs
   always_comb begin
      sram_ce_n                = 1'b1;
      sram_oe_n                = 1'b1;
      sram_we_n                = 1'b1;
      sram_ub_n                = 1'b1;
      sram_lb_n                = 1'b1;
      sram_direccion           = '0;
      conduce                  = 1'b0;
      bus.ocupado              = (estado_q != E_REPOSO);
      bus.operacion_completada = (estado_q == E_COMPLETO);
      if (estado_q == E_PREPARAR || estado_q == E_ACCESO || estado_q == E_RETENER) begin
         sram_ce_n      = 1'b0;
         sram_ub_n      = 1'b0;
         sram_lb_n      = 1'b0;
         // modular add: the last sub-accesses wrap to address 0
         sram_direccion = base_q + ADDRESS_BITS'(k_q);
         // write data stays on the bus around the we_n pulse for setup/hold
         conduce        = escritura_q;
         if (estado_q == E_ACCESO) begin
            if (escritura_q) sram_we_n = 1'b0;
            else             sram_oe_n = 1'b0;
         end
      end
   end

   assign sram_datos       = conduce ? wdata_q[k_q*SRAM_BITS +: SRAM_BITS] : {SRAM_BITS{1'bz}};
   assign bus.datos_leidos = rdata_q;

endmodule

// File: tb/tb_controlador_sram_64.sv
module tb_controlador_sram_64;
   localparam int AB = 18;
   localparam int DB = 64;
   localparam int SB = 16;
   // wait cycles per instance: [0]=2 (main), [1]=1, [2]=4
   localparam logic [2:0][7:0] CE_TAB = {8'd4, 8'd1, 8'd2};

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          inst;
      int          ciclo;
      logic [63:0] dato;
   } esp_t;
   typedef struct {
      logic [17:0] dir;
      logic [15:0] dato;
   } wlog_t;

   esp_t  q[$];
   wlog_t wlog[$];
   int    n_chk = 0;
   int    n_fail = 0;
   logic [63:0] exp_rd [3];

   logic        leer_s [3], esc_s [3];
   logic [17:0] dir_s [3];
   logic [63:0] wd_s [3];
   logic        pulso [3], ocup [3];
   logic [63:0] rd [3];
   logic        ce_n [3], oe_n [3], we_n [3], ub_n [3], lb_n [3];
   logic [17:0] sdir [3];
   logic [15:0] sdat [3];

   for (genvar i = 0; i < 3; i++) begin : g
      controlador_sram_64_if #(.ADDRESS_BITS(AB), .DATA_BITS(DB)) ifc ();
      wire  [15:0] bus;
      logic        ce, oe, we, ub, lb;
      logic [17:0] a;
      logic [15:0] mem [0:(1<<AB)-1];

      assign ifc.leer               = leer_s[i];
      assign ifc.escribir           = esc_s[i];
      assign ifc.direccion_memoria  = dir_s[i];
      assign ifc.datos_por_escribir = wd_s[i];
      assign pulso[i] = ifc.operacion_completada;
      assign ocup[i]  = ifc.ocupado;
      assign rd[i]    = ifc.datos_leidos;
      assign ce_n[i] = ce;
      assign oe_n[i] = oe;
      assign we_n[i] = we;
      assign ub_n[i] = ub;
      assign lb_n[i] = lb;
      assign sdir[i] = a;
      assign sdat[i] = bus;

      controlador_sram_64 #(
         .ADDRESS_BITS(AB), .DATA_BITS(DB), .SRAM_BITS(SB),
         .CICLOS_ESPERA(int'(CE_TAB[i]))
      ) dut (
         .clk(clk), .reset(reset), .bus(ifc),
         .sram_direccion(a), .sram_datos(bus),
         .sram_ce_n(ce), .sram_oe_n(oe), .sram_we_n(we),
         .sram_ub_n(ub), .sram_lb_n(lb)
      );

      // asynchronous SRAM model
      assign bus = (!ce && !oe && we) ? mem[a] : 16'bz;
      always @(posedge clk) if (!ce && !we) mem[a] <= bus;
   end

   function automatic int lat(int i);
      return 4 * (int'(CE_TAB[i]) + 2) + 1;
   endfunction

   function automatic int pend(int i);
      int n = 0;
      foreach (q[j]) if (q[j].inst == i) n++;
      return n;
   endfunction

   task automatic chk(bit ok, string nom, string det);
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: %s", nom, det);
      end
   endtask

   // Scoreboard side: pops the expectation of an instance whenever it pulses,
   // plus a per-cycle strobe protocol check.
   task automatic monitor();
      logic we_prev = 1'b1;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            if (!oe_n[i] || !we_n[i])
               chk((oe_n[i] || we_n[i]) && !ce_n[i] && !ub_n[i] && !lb_n[i], "protocolo",
                   $sformatf("inst %0d cyc %0d ce=%b oe=%b we=%b ub=%b lb=%b", i, cyc,
                             ce_n[i], oe_n[i], we_n[i], ub_n[i], lb_n[i]));
            if (pulso[i]) begin
               int k = -1;
               foreach (q[j]) if (k < 0 && q[j].inst == i) k = j;
               if (k < 0) begin
                  chk(1'b0, "pulso_inesperado", $sformatf("inst %0d cyc %0d", i, cyc));
               end else begin
                  chk(cyc == q[k].ciclo && ocup[i] && rd[i] == q[k].dato, "respuesta",
                      $sformatf("inst %0d got cyc %0d ocupado %b dato %h, want cyc %0d ocupado 1 dato %h",
                                i, cyc, ocup[i], rd[i], q[k].ciclo, q[k].dato));
                  q.delete(k);
               end
            end
         end
         if (!we_n[0] && we_prev) wlog.push_back('{sdir[0], sdat[0]});
         we_prev = we_n[0];
      end
   endtask

   // Called at a negedge; the request is accepted at the next posedge.
   task automatic pedir(int i, bit lee, bit esc, logic [17:0] d, logic [63:0] w,
                        bit resp, logic [63:0] leido);
      leer_s[i] = lee;
      esc_s[i]  = esc;
      dir_s[i]  = d;
      wd_s[i]   = w;
      if (resp) begin
         if (!esc) exp_rd[i] = leido;
         q.push_back('{i, cyc + lat(i), exp_rd[i]});
      end
      @(negedge clk);
      leer_s[i] = 1'b0;
      esc_s[i]  = 1'b0;
   endtask

   task automatic esperar(int i);
      int n = 0;
      while (pend(i) != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk(pend(i) == 0, "timeout", $sformatf("inst %0d still %0d pending", i, pend(i)));
      foreach (q[j]) if (q[j].inst == i) q.delete(j);
      @(negedge clk);
   endtask

   task automatic chk_log(int idx, logic [17:0] d, logic [15:0] v);
      if (idx >= wlog.size())
         chk(1'b0, "wlog", $sformatf("entry %0d missing, want %h=%h", idx, d, v));
      else
         chk(wlog[idx].dir == d && wlog[idx].dato == v, "wlog",
             $sformatf("entry %0d got %h=%h want %h=%h", idx, wlog[idx].dir, wlog[idx].dato, d, v));
   endtask

   initial begin
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         leer_s[i] = 1'b0; esc_s[i] = 1'b0; dir_s[i] = '0; wd_s[i] = '0; exp_rd[i] = '0;
      end
      fork monitor(); join_none
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++)
         chk(ce_n[i] && oe_n[i] && we_n[i] && ub_n[i] && lb_n[i] && !ocup[i] && !pulso[i]
             && rd[i] == 64'h0 && sdir[i] == 18'h0, "reset",
             $sformatf("inst %0d ce%b oe%b we%b ocup%b pulso%b rd %h dir %h",
                       i, ce_n[i], oe_n[i], we_n[i], ocup[i], pulso[i], rd[i], sdir[i]));
      reset = 1'b1;
      @(negedge clk);

      // reference word, then a write aborted by reset on cycle 5 (first sub-word done)
      pedir(0, 0, 1, 18'h00100, 64'h1111_2222_3333_4444, 1, 0);
      esperar(0);
      pedir(0, 0, 1, 18'h00100, 64'hAAAA_BBBB_CCCC_DDDD, 0, 0);
      repeat (4) @(negedge clk);
      reset = 1'b0;
      #1;
      chk(ce_n[0] && oe_n[0] && we_n[0] && ub_n[0] && lb_n[0] && !ocup[0] && !pulso[0]
          && sdir[0] == 18'h0, "reset_abort",
          $sformatf("ce%b oe%b we%b ocup%b pulso%b dir %h", ce_n[0], oe_n[0], we_n[0],
                    ocup[0], pulso[0], sdir[0]));
      exp_rd[0] = '0;
      @(negedge clk);
      reset = 1'b1;
      repeat (20) @(negedge clk);
      pedir(0, 1, 0, 18'h00100, 64'h0, 1, 64'h1111_2222_3333_DDDD);
      esperar(0);

      // write 0x20000, sub-word order and addresses
      wlog.delete();
      pedir(0, 0, 1, 18'h20000, 64'h0123_4567_89AB_CDEF, 1, 0);
      esperar(0);
      chk(wlog.size() == 4, "wlog_len", $sformatf("got %0d want 4", wlog.size()));
      chk_log(0, 18'h20000, 16'hCDEF);
      chk_log(1, 18'h20001, 16'h89AB);
      chk_log(2, 18'h20002, 16'h4567);
      chk_log(3, 18'h20003, 16'h0123);
      pedir(0, 1, 0, 18'h20000, 64'h0, 1, 64'h0123_4567_89AB_CDEF);
      esperar(0);

      // address wrap
      wlog.delete();
      pedir(0, 0, 1, 18'h3FFFE, 64'hDEAD_BEEF_CAFE_F00D, 1, 0);
      esperar(0);
      chk_log(0, 18'h3FFFE, 16'hF00D);
      chk_log(1, 18'h3FFFF, 16'hCAFE);
      chk_log(2, 18'h00000, 16'hBEEF);
      chk_log(3, 18'h00001, 16'hDEAD);

      // leer+escribir together: only the write runs
      wlog.delete();
      pedir(0, 1, 1, 18'h00500, 64'h5555_6666_7777_8888, 1, 0);
      esperar(0);
      chk(wlog.size() == 4, "prioridad", $sformatf("got %0d write strobes want 4", wlog.size()));
      pedir(0, 1, 0, 18'h00500, 64'h0, 1, 64'h5555_6666_7777_8888);
      esperar(0);

      // leer while busy is ignored: one pulse, datos_leidos untouched
      pedir(0, 0, 1, 18'h00600, 64'h9999_AAAA_BBBB_CCCC, 1, 0);
      repeat (3) @(negedge clk);
      pedir(0, 1, 0, 18'h20000, 64'h0, 0, 0);
      esperar(0);
      repeat (25) @(negedge clk);

      // other wait settings: latency 13 and 25
      for (int i = 1; i < 3; i++) begin
         pedir(i, 0, 1, 18'h00040, 64'h0123_4567_89AB_CDEF, 1, 0);
         esperar(i);
         pedir(i, 1, 0, 18'h00040, 64'h0, 1, 64'h0123_4567_89AB_CDEF);
         esperar(i);
      end

      chk(q.size() == 0, "cola_vacia", $sformatf("got %0d pending want 0", q.size()));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
